instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have port clk, input, 1: single rising-edge clock for all state.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port pc_f, output, 32: fetch address driven to the combinational instruction memory.
REQ-005 SHALL have port instr_f, input, 32: instruction word returned by memory for pc_f in the same cycle.
REQ-006 SHALL have port stall_f, input, 1: hold pc_f.
REQ-007 SHALL have port stall_d, input, 1: hold the IF/ID register.
REQ-008 SHALL have port flush_d, input, 1: replace the IF/ID contents with a bubble.
REQ-009 SHALL have port pc_src_e, input, 1: redirect request from Execute (taken branch or jump).
REQ-010 SHALL have port pc_target_e, input, 32: redirect target.
REQ-011 SHALL have ports instr_d, pc_d, pc_plus4_d, outputs, 32 each: IF/ID register contents.
REQ-012 SHALL have port valid_d, output, 1: instr_d holds a real fetched instruction.
REQ-013 SHALL have port misalign_f, output, 1: one-cycle pulse when an accepted redirect target has bits [1:0] != 0.
REQ-014 SHALL have port fetch_count, output, 32: number of instructions delivered into the IF/ID register.

Function
REQ-015 SHALL compute pc_plus4_f = pc_f + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
REQ-016 SHALL select next PC with priority: pc_src_e first, then stall_f (hold), else pc_plus4_f.
REQ-017 SHALL load {pc_target_e[31:2], 2'b00} on redirect; redirect SHALL override stall_f in the same cycle.
REQ-018 SHALL assert misalign_f in the cycle after a redirect whose pc_target_e[1:0] != 0, and deassert it otherwise.
REQ-019 SHALL update the IF/ID register with priority: flush_d first, then stall_d (hold), else load {instr_f, pc_f, pc_plus4_f} with valid_d = 1.
REQ-020 SHALL load a flush as instr_d = 32'h0000_0013 (NOP), pc_d = 0, pc_plus4_d = 0, valid_d = 0; flush SHALL override stall_d.
REQ-021 SHALL treat instr_f == 0 (unmapped memory) as a normal load with valid_d = 1; decode handles it.
REQ-022 SHALL have a latency of one cycle from pc_f to instr_d.
REQ-023 SHALL have no combinational path from any input to pc_f; pc_f comes from a register.
REQ-024 SHALL increment fetch_count by 1 on each edge where the IF/ID register loads with valid_d = 1; it SHALL NOT change on stall or flush, and SHALL wrap modulo 2^32.
REQ-025 SHALL keep stall_f = 1 with stall_d = 0 legal: the same instruction is reloaded and counted each cycle; hazard logic must not assert this.

Reset
REQ-026 SHALL, while reset = 1 and independent of clk, force: pc_f = RESET_PC; instr_d = NOP; pc_d = 0; pc_plus4_d = 0; valid_d = 0; misalign_f = 0; fetch_count = 0.
REQ-027 SHALL discard any in-flight redirect, stall, or flush on reset assertion mid-operation.
REQ-028 SHALL, on the first rising edge after reset deasserts, load the instruction at RESET_PC into IF/ID and advance pc_f to RESET_PC + 4.

Structure
REQ-029 SHALL place NOP_INSTR (32'h0000_0013), XLEN (32) and default RESET_PC in the shared package riscv_pkg.
REQ-030 SHALL implement the IF/ID register as one sub-module, pipe_reg_enrc (enable, synchronous clear, asynchronous reset, parameterised width and clear value), instantiated once.
REQ-031 SHALL instantiate no memory; instruction storage stays external.

Verification
REQ-032 SHALL cover reset then free run, with memory 0x0→0x00420413 and 0x4→0x00947133: cycle 1 gives instr_d = 0x00420413, pc_d = 0, pc_plus4_d = 4; cycle 2 gives instr_d = 0x00947133, pc_d = 4; fetch_count = 2.
REQ-033 SHALL cover stall_f = stall_d = 1 for 3 cycles at pc_f = 0x8: pc_f stays 0x8, IF/ID is held, fetch_count is unchanged.
REQ-034 SHALL cover pc_src_e = 1, pc_target_e = 0x0, and flush_d = 1 together with stall_f = 1: next pc_f = 0x0, instr_d = 0x00000013, valid_d = 0.
REQ-035 SHALL cover redirect to 0x0000_0006: pc_f = 0x4, misalign_f is high for exactly one cycle.
REQ-036 SHALL cover pc_f = 0xFFFF_FFFC free running: next pc_f = 0x0, pc_plus4_d = 0x0.
REQ-037 SHALL cover reset asserted mid-cycle while stall_d = 1: outputs take reset values immediately, before the next clk edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared constants and types for the RISC-V front end.
//   XLEN             : datapath width
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0) used as the pipeline bubble
//   DEFAULT_RESET_PC : PC loaded on reset unless overridden
//   if_id_t          : IF/ID register layout
//   IF_ID_BUBBLE     : IF/ID contents after a flush or reset
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{
    instr:    NOP_INSTR,
    pc:       '0,
    pc_plus4: '0,
    valid:    1'b0
  };

  // Word-aligned successor address; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/pipe_reg_enrc.sv
// Pipeline register with enable, synchronous clear and asynchronous reset.
// The reset value equals the clear value, so a reset looks like a bubble.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset, forces q = CLR_VAL
//   en   : load d on the next edge
//   clr  : load CLR_VAL on the next edge; wins over en
//   d    : data in
//   q    : registered data out
module pipe_reg_enrc #(
  parameter int unsigned           WIDTH   = 32,
  parameter logic [WIDTH-1:0]      CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (clr) begin
      data_d = CLR_VAL;
    end else if (en) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= CLR_VAL;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID register
// and a count of instructions delivered into IF/ID.
//   clk, reset          : clock and asynchronous active-high reset
//   pc_f                : registered fetch address to external memory
//   instr_f             : memory data for pc_f (combinational memory)
//   stall_f / stall_d   : hold the PC / hold the IF/ID register
//   flush_d             : load a bubble into IF/ID (wins over stall_d)
//   pc_src_e, pc_target_e : redirect from Execute (wins over stall_f)
//   instr_d, pc_d, pc_plus4_d, valid_d : IF/ID contents
//   misalign_f          : one-cycle pulse after a redirect with target[1:0] != 0
//   fetch_count         : number of valid loads into IF/ID, wraps modulo 2^32
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc_f,
  input  logic [XLEN-1:0] instr_f,
  input  logic            stall_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            pc_src_e,
  input  logic [XLEN-1:0] pc_target_e,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pc_plus4_d,
  output logic            valid_d,
  output logic            misalign_f,
  output logic [XLEN-1:0] fetch_count
);

  logic [XLEN-1:0] pc_q, pc_d_nxt;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] fetch_count_q, fetch_count_d;
  logic [XLEN-1:0] pc_plus4_f;
  logic            if_id_load;
  if_id_t          if_id_in;
  if_id_t          if_id_out;

  assign pc_plus4_f = next_seq_pc(pc_q);

  // IF/ID takes a real instruction only when neither flushed nor stalled.
  assign if_id_load = !flush_d && !stall_d;

  always_comb begin
    pc_d_nxt = pc_plus4_f;
    if (pc_src_e) begin
      // Targets are forced to word alignment; misalign_f reports the fixup.
      pc_d_nxt = {pc_target_e[XLEN-1:2], 2'b00};
    end else if (stall_f) begin
      pc_d_nxt = pc_q;
    end
  end

  always_comb begin
    misalign_d = pc_src_e && (pc_target_e[1:0] != 2'b00);
  end

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (if_id_load) begin
      fetch_count_d = fetch_count_q + XLEN'(1);
    end
  end

  always_comb begin
    if_id_in          = IF_ID_BUBBLE;
    if_id_in.instr    = instr_f;
    if_id_in.pc       = pc_q;
    if_id_in.pc_plus4 = pc_plus4_f;
    if_id_in.valid    = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      misalign_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d_nxt;
      misalign_q    <= misalign_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  pipe_reg_enrc #(
    .WIDTH   ($bits(if_id_t)),
    .CLR_VAL (IF_ID_BUBBLE)
  ) u_if_id (
    .clk (clk),
    .rst (reset),
    .en  (!stall_d),
    .clr (flush_d),
    .d   (if_id_in),
    .q   (if_id_out)
  );

  assign pc_f        = pc_q;
  assign misalign_f  = misalign_q;
  assign fetch_count = fetch_count_q;
  assign instr_d     = if_id_out.instr;
  assign pc_d        = if_id_out.pc;
  assign pc_plus4_d  = if_id_out.pc_plus4;
  assign valid_d     = if_id_out.valid;

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized stall/flush/redirect traffic against a behavioural model.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic [31:0] pc_f;
  logic [31:0] instr_f;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pc_src_e;
  logic [31:0] pc_target_e;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic        misalign_f;
  logic [31:0] fetch_count;

  int errors = 0;
  int checks = 0;

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk         (clk),
    .reset       (reset),
    .pc_f        (pc_f),
    .instr_f     (instr_f),
    .stall_f     (stall_f),
    .stall_d     (stall_d),
    .flush_d     (flush_d),
    .pc_src_e    (pc_src_e),
    .pc_target_e (pc_target_e),
    .instr_d     (instr_d),
    .pc_d        (pc_d),
    .pc_plus4_d  (pc_plus4_d),
    .valid_d     (valid_d),
    .misalign_f  (misalign_f),
    .fetch_count (fetch_count)
  );

  // Behavioural instruction memory; addresses with bits [7:4] == 4'hA read 0.
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a == 32'h0) return 32'h0042_0413;
    if (a == 32'h4) return 32'h0094_7133;
    if (a[7:4] == 4'hA) return 32'h0;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign instr_f = mem_read(pc_f);

  // ---------------- reference model ----------------
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4, m_cnt;
  logic        m_valid, m_mis;
  logic [31:0] exp_q[$];

  task automatic model_reset();
    m_pc = 32'h0; m_instr = NOP; m_pcd = 0; m_pc4 = 0;
    m_valid = 0; m_mis = 0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [31:0] fetched_pc;
    fetched_pc = m_pc;
    if (flush_d) begin
      m_instr = NOP; m_pcd = 0; m_pc4 = 0; m_valid = 0;
    end else if (!stall_d) begin
      m_instr = mem_read(fetched_pc); m_pcd = fetched_pc;
      m_pc4 = fetched_pc + 32'd4; m_valid = 1; m_cnt = m_cnt + 1;
    end
    m_mis = pc_src_e && (pc_target_e % 4 != 0);
    if (pc_src_e) m_pc = pc_target_e - (pc_target_e % 4);
    else if (!stall_f) m_pc = fetched_pc + 32'd4;
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    exp_q = {m_pc, m_instr, m_pcd, m_pc4, 32'(m_valid), 32'(m_mis), m_cnt};
    check({tag, ".pc_f"},        pc_f,              exp_q[0]);
    check({tag, ".instr_d"},     instr_d,           exp_q[1]);
    check({tag, ".pc_d"},        pc_d,              exp_q[2]);
    check({tag, ".pc_plus4_d"},  pc_plus4_d,        exp_q[3]);
    check({tag, ".valid_d"},     32'(valid_d),      exp_q[4]);
    check({tag, ".misalign_f"},  32'(misalign_f),   exp_q[5]);
    check({tag, ".fetch_count"}, fetch_count,       exp_q[6]);
    exp_q.delete();
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic sf, input logic sd, input logic fl,
                      input logic src, input logic [31:0] tgt, input string tag);
    stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic free_run(input string tag);
    step(0, 0, 0, 0, 32'h0, tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_all("reset");
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    do_reset();

    // Free run from reset: first two instructions.
    free_run("run1");
    check("run1.instr_lit", instr_d, 32'h0042_0413);
    check("run1.pc4_lit", pc_plus4_d, 32'h4);
    free_run("run2");
    check("run2.instr_lit", instr_d, 32'h0094_7133);
    check("run2.pc_d_lit", pc_d, 32'h4);
    check("run2.count_lit", fetch_count, 32'd2);

    // Full stall at pc 0x8 for three cycles.
    check("stall.pc_start", pc_f, 32'h8);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 32'h0, "stall");
    check("stall.pc_lit", pc_f, 32'h8);
    check("stall.count_lit", fetch_count, 32'd2);

    // Fetch-only stall: same instruction reloaded and counted.
    step(1, 0, 0, 0, 32'h0, "fstall");
    step(1, 0, 0, 0, 32'h0, "fstall");

    // Redirect with flush while fetch is stalled.
    step(1, 0, 1, 1, 32'h0, "redir_flush");
    check("redir_flush.pc_lit", pc_f, 32'h0);
    check("redir_flush.instr_lit", instr_d, NOP);
    check("redir_flush.valid_lit", 32'(valid_d), 32'h0);

    // Misaligned redirect: one-cycle pulse.
    step(0, 0, 0, 1, 32'h6, "mis");
    check("mis.pc_lit", pc_f, 32'h4);
    check("mis.pulse", 32'(misalign_f), 32'h1);
    free_run("mis_after");
    check("mis_after.pulse", 32'(misalign_f), 32'h0);

    // Flush wins over stall_d.
    step(0, 1, 1, 0, 32'h0, "flush_stall");

    // Wrap at top of address space.
    step(0, 0, 0, 1, 32'hFFFF_FFFC, "to_top");
    free_run("wrap");
    check("wrap.pc_lit", pc_f, 32'h0);
    check("wrap.pc4_lit", pc_plus4_d, 32'h0);

    // Unmapped memory word is a normal valid load.
    step(0, 0, 0, 1, 32'h0000_00A0, "to_unmapped");
    free_run("unmapped");
    check("unmapped.instr_lit", instr_d, 32'h0);

    // Asynchronous reset in mid-cycle while stall_d is high.
    step(1, 1, 0, 0, 32'h0, "pre_reset");
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_all("async_reset");
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    free_run("post_reset");

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic sf, sd, fl, src;
      logic [31:0] tgt;
      sf  = ($urandom_range(0, 99) < 20);
      sd  = ($urandom_range(0, 99) < 20);
      fl  = ($urandom_range(0, 99) < 10);
      src = ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 3))
        0: tgt = 32'($urandom_range(0, 255));
        1: tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        2: tgt = 32'h0000_00A0 + 32'($urandom_range(0, 15));
        default: tgt = $urandom;
      endcase
      step(sf, sd, fl, src, tgt, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
